pipe_hazard_ctrl: RTL and testbench

Hazard controller for the five-stage PPCPU pipeline (IF, ID, Ex, Mem, Wr). It tracks per-stage instruction validity and detects load-use hazards, inserting one bubble. It resolves taken branches and jumps (decided in Mem) by flushing younger stages, and drives operand-forwarding selects for the Ex-stage ALU and the ID-stage register read. Saturating stall and flush counters support performance debug.

---
 rtl/pipe_hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | pipe_hazard_ctrl                                                       |
// | Load-use stall, branch/jump flush and operand-forwarding control for a |
// | five-stage pipeline, with saturating stall and flush event counters.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [4:0]       D_Rs,
  input  logic [4:0]       D_Rt,
  input  logic             D_UseRs,
  input  logic             D_UseRt,
  input  logic [4:0]       E_Rs,
  input  logic [4:0]       E_Rt,
  input  logic [4:0]       E_Rw,
  input  logic             E_RegWr,
  input  logic             E_MemtoReg,
  input  logic [4:0]       M_Rw,
  input  logic             M_RegWr,
  input  logic             M_MemtoReg,
  input  logic             M_PCSrc,
  input  logic [4:0]       W_Rw,
  input  logic             W_RegWr,
  output logic             PC_WE,
  output logic             IFID_WE,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             EXMEM_Flush,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             FwdDA,
  output logic             FwdDB,
  output logic             D_Valid,
  output logic             E_Valid,
  output logic             M_Valid,
  output logic             W_Valid,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    LDSTALL = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             d_valid_q, d_valid_d;
  logic             e_valid_q, e_valid_d;
  logic             m_valid_q, m_valid_d;
  logic             w_valid_q, w_valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic redir;
  logic ld_use;
  logic stall;
  logic m_fwd_ok;
  logic w_fwd_ok;

  assign redir  = m_valid_q & M_PCSrc;
  assign ld_use = ~redir & d_valid_q & e_valid_q & E_RegWr & E_MemtoReg &
                  (E_Rw != 5'd0) &
                  ((D_UseRs & (D_Rs == E_Rw)) | (D_UseRt & (D_Rt == E_Rw)));
  // The bubble inserted by a stall must not re-trigger the same hazard.
  assign stall  = ld_use & (state_q == RUN);

  // A load still in Mem has no data yet, so only ALU results forward from Mem.
  assign m_fwd_ok = m_valid_q & M_RegWr & ~M_MemtoReg & (M_Rw != 5'd0);
  assign w_fwd_ok = w_valid_q & W_RegWr & (W_Rw != 5'd0);

  always_comb begin
    PC_WE       = 1'b1;
    IFID_WE     = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    EXMEM_Flush = 1'b0;
    if (Reset) begin
      PC_WE       = 1'b0;
      IFID_WE     = 1'b0;
      IFID_Flush  = 1'b1;
      IDEX_Flush  = 1'b1;
      EXMEM_Flush = 1'b1;
    end else if (redir) begin
      IFID_Flush  = 1'b1;
      IDEX_Flush  = 1'b1;
      EXMEM_Flush = 1'b1;
    end else if (stall) begin
      PC_WE      = 1'b0;
      IFID_WE    = 1'b0;
      IDEX_Flush = 1'b1;
    end
  end

  always_comb begin
    ForwardA = 2'b00;
    ForwardB = 2'b00;
    FwdDA    = 1'b0;
    FwdDB    = 1'b0;
    if (!Reset) begin
      if (m_fwd_ok && (M_Rw == E_Rs))      ForwardA = 2'b01;
      else if (w_fwd_ok && (W_Rw == E_Rs)) ForwardA = 2'b10;
      if (m_fwd_ok && (M_Rw == E_Rt))      ForwardB = 2'b01;
      else if (w_fwd_ok && (W_Rw == E_Rt)) ForwardB = 2'b10;
      FwdDA = w_fwd_ok & (W_Rw == D_Rs);
      FwdDB = w_fwd_ok & (W_Rw == D_Rt);
    end
  end

  always_comb begin
    state_d     = RUN;
    d_valid_d   = redir ? 1'b0 : (stall ? d_valid_q : 1'b1);
    e_valid_d   = (redir | stall) ? 1'b0 : d_valid_q;
    m_valid_d   = redir ? 1'b0 : e_valid_q;
    w_valid_d   = m_valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (state_q == RUN && stall) state_d = LDSTALL;
    if (stall && stall_cnt_q != C_CNT_MAX) stall_cnt_d = stall_cnt_q + C_CNT_ONE;
    if (redir && flush_cnt_q != C_CNT_MAX) flush_cnt_d = flush_cnt_q + C_CNT_ONE;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= RUN;
      d_valid_q   <= 1'b0;
      e_valid_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      w_valid_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      d_valid_q   <= d_valid_d;
      e_valid_q   <= e_valid_d;
      m_valid_q   <= m_valid_d;
      w_valid_q   <= w_valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign D_Valid  = d_valid_q;
  assign E_Valid  = e_valid_q;
  assign M_Valid  = m_valid_q;
  assign W_Valid  = w_valid_q;
  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_pipe_hazard_ctrl                                                    |
// | Instruction-level pipeline model driving pipe_hazard_ctrl; expected    |
// | outputs are queued per cycle and compared mid-cycle.                   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs, rt, rw;
    logic       urs, urt, wr, m2r, pcs;
    logic [7:0] tgt;
  } ins_t;

  typedef struct packed {
    logic [4:0]  ctl;
    logic [5:0]  fwd;
    logic [3:0]  vld;
    logic [15:0] sc, fc;
    logic [1:0]  nsc;
  } exp_t;

  logic Clk = 1'b0, Reset = 1'b1;
  logic [4:0] D_Rs = '0, D_Rt = '0, E_Rs = '0, E_Rt = '0, E_Rw = '0, M_Rw = '0, W_Rw = '0;
  logic D_UseRs = 0, D_UseRt = 0, E_RegWr = 0, E_MemtoReg = 0;
  logic M_RegWr = 0, M_MemtoReg = 0, M_PCSrc = 0, W_RegWr = 0;
  logic PC_WE, IFID_WE, IFID_Flush, IDEX_Flush, EXMEM_Flush, FwdDA, FwdDB;
  logic [1:0] ForwardA, ForwardB;
  logic D_Valid, E_Valid, M_Valid, W_Valid;
  logic [15:0] StallCnt, FlushCnt;
  logic n_pcwe, n_ifidwe, n_f1, n_f2, n_f3, n_fda, n_fdb, n_dv, n_ev, n_mv, n_wv;
  logic [1:0] n_fa, n_fb, n_sc, n_fc;

  always #5 Clk = ~Clk;

  pipe_hazard_ctrl #(.CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .D_Rs(D_Rs), .D_Rt(D_Rt), .D_UseRs(D_UseRs), .D_UseRt(D_UseRt),
    .E_Rs(E_Rs), .E_Rt(E_Rt), .E_Rw(E_Rw), .E_RegWr(E_RegWr), .E_MemtoReg(E_MemtoReg),
    .M_Rw(M_Rw), .M_RegWr(M_RegWr), .M_MemtoReg(M_MemtoReg), .M_PCSrc(M_PCSrc),
    .W_Rw(W_Rw), .W_RegWr(W_RegWr), .PC_WE(PC_WE), .IFID_WE(IFID_WE),
    .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush), .EXMEM_Flush(EXMEM_Flush),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .FwdDA(FwdDA), .FwdDB(FwdDB),
    .D_Valid(D_Valid), .E_Valid(E_Valid), .M_Valid(M_Valid), .W_Valid(W_Valid),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  // Narrow-counter copy on the same stimulus exposes saturation quickly.
  pipe_hazard_ctrl #(.CNT_W(2)) dut_n (
    .Clk(Clk), .Reset(Reset), .D_Rs(D_Rs), .D_Rt(D_Rt), .D_UseRs(D_UseRs), .D_UseRt(D_UseRt),
    .E_Rs(E_Rs), .E_Rt(E_Rt), .E_Rw(E_Rw), .E_RegWr(E_RegWr), .E_MemtoReg(E_MemtoReg),
    .M_Rw(M_Rw), .M_RegWr(M_RegWr), .M_MemtoReg(M_MemtoReg), .M_PCSrc(M_PCSrc),
    .W_Rw(W_Rw), .W_RegWr(W_RegWr), .PC_WE(n_pcwe), .IFID_WE(n_ifidwe),
    .IFID_Flush(n_f1), .IDEX_Flush(n_f2), .EXMEM_Flush(n_f3),
    .ForwardA(n_fa), .ForwardB(n_fb), .FwdDA(n_fda), .FwdDB(n_fdb),
    .D_Valid(n_dv), .E_Valid(n_ev), .M_Valid(n_mv), .W_Valid(n_wv),
    .StallCnt(n_sc), .FlushCnt(n_fc)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  ins_t prog[$];

  ins_t md, me, mm, mw;
  logic dv, ev, mv, wv, bub;
  int   pc;
  logic [15:0] sc, fc;
  logic [1:0]  nsc;
  logic cyc_redir, cyc_lu;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic ins_t mk(input int rs, input int rt, input int rw, input bit urs,
                              input bit urt, input bit wr, input bit m2r, input bit pcs,
                              input int tgt);
    ins_t i;
    i.rs = 5'(rs); i.rt = 5'(rt); i.rw = 5'(rw);
    i.urs = urs; i.urt = urt; i.wr = wr; i.m2r = m2r; i.pcs = pcs; i.tgt = 8'(tgt);
    return i;
  endfunction

  function automatic ins_t fetch(input int p);
    return (p < prog.size()) ? prog[p] : '0;
  endfunction

  function automatic logic [1:0] exp_alu_fwd(input logic [4:0] r);
    if (mv && mm.wr && !mm.m2r && mm.rw != 0 && mm.rw == r) return 2'b01;
    if (wv && mw.wr && mw.rw != 0 && mw.rw == r)            return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic wr_hits(input logic [4:0] r);
    return wv && mw.wr && mw.rw != 0 && mw.rw == r;
  endfunction

  function automatic logic id_reads(input logic [4:0] r);
    return r != 0 && ((md.urs && md.rs == r) || (md.urt && md.rt == r));
  endfunction

  task automatic model_reset();
    md = '0; me = '0; mm = '0; mw = '0;
    dv = 0; ev = 0; mv = 0; wv = 0; bub = 0; pc = 0;
    sc = '0; fc = '0; nsc = '0;
  endtask

  task automatic drive();
    D_Rs = md.rs; D_Rt = md.rt; D_UseRs = md.urs; D_UseRt = md.urt;
    E_Rs = me.rs; E_Rt = me.rt; E_Rw = me.rw; E_RegWr = me.wr; E_MemtoReg = me.m2r;
    M_Rw = mm.rw; M_RegWr = mm.wr; M_MemtoReg = mm.m2r; M_PCSrc = mm.pcs;
    W_Rw = mw.rw; W_RegWr = mw.wr;
  endtask

  task automatic compare_head();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check_eq("ctl", {27'd0, PC_WE, IFID_WE, IFID_Flush, IDEX_Flush, EXMEM_Flush}, {27'd0, e.ctl});
    check_eq("fwd", {26'd0, ForwardA, ForwardB, FwdDA, FwdDB}, {26'd0, e.fwd});
    check_eq("valid", {28'd0, D_Valid, E_Valid, M_Valid, W_Valid}, {28'd0, e.vld});
    check_eq("stall_cnt", {16'd0, StallCnt}, {16'd0, e.sc});
    check_eq("flush_cnt", {16'd0, FlushCnt}, {16'd0, e.fc});
    check_eq("stall_cnt_narrow", {30'd0, n_sc}, {30'd0, e.nsc});
  endtask

  task automatic step();
    exp_t e;
    logic [7:0] tgt;
    drive();
    cyc_redir = mv && mm.pcs;
    cyc_lu = !cyc_redir && !bub && dv && ev && me.wr && me.m2r && id_reads(me.rw);
    e.ctl = cyc_redir ? 5'b11111 : (cyc_lu ? 5'b00010 : 5'b11000);
    e.fwd = {exp_alu_fwd(me.rs), exp_alu_fwd(me.rt), wr_hits(md.rs), wr_hits(md.rt)};
    e.vld = {dv, ev, mv, wv};
    e.sc = sc; e.fc = fc; e.nsc = nsc;
    sb_q.push_back(e);
    @(negedge Clk);
    compare_head();
    @(posedge Clk);
    wv = mv; mw = mm;
    if (cyc_redir) begin
      tgt = mm.tgt;
      mm = '0; mv = 0; me = '0; ev = 0; md = '0; dv = 0;
      pc = int'(tgt); bub = 0;
      if (fc != 16'hFFFF) fc++;
    end else if (cyc_lu) begin
      mm = me; mv = ev; me = '0; ev = 0; bub = 1;
      if (sc != 16'hFFFF) sc++;
      if (nsc != 2'b11) nsc++;
    end else begin
      mm = me; mv = ev; me = md; ev = dv;
      md = fetch(pc); pc++; dv = 1; bub = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    exp_t e;
    Reset = 1;
    model_reset();
    drive();
    e.ctl = 5'b00111; e.fwd = '0; e.vld = '0; e.sc = '0; e.fc = '0; e.nsc = '0;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(e);
      @(negedge Clk);
      compare_head();
      @(posedge Clk);
      #1;
    end
    Reset = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Load-use: lw $2,0($1); add $3,$2,$4
    prog = '{mk(1,2,2,1,0,1,1,0,0), mk(2,4,3,1,1,1,0,0,0)};
    do_reset();
    run(10);
    check_eq("loaduse_stalls", {16'd0, StallCnt}, 32'd1);

    // ALU chain: add $5,$1,$1; sub $6,$5,$5; or $7,$5,$0
    prog = '{mk(1,1,5,1,1,1,0,0,0), mk(5,5,6,1,1,1,0,0,0), mk(5,0,7,1,1,1,0,0,0)};
    do_reset();
    run(11);
    check_eq("alu_chain_stalls", {16'd0, StallCnt}, 32'd0);

    // $0 destination: add $0,$1,$1; add $8,$0,$0
    prog = '{mk(1,1,0,1,1,1,0,0,0), mk(0,0,8,1,1,1,0,0,0)};
    do_reset();
    run(10);

    // Taken beq to index 5; indices 1..3 are on the wrong path
    prog = '{mk(1,2,0,1,1,0,0,1,5), mk(1,1,9,1,1,1,0,0,0), mk(9,9,10,1,1,1,0,0,0),
             mk(10,10,11,1,1,1,0,0,0), mk(11,11,14,1,1,1,0,0,0), mk(9,9,12,1,1,1,0,0,0)};
    do_reset();
    run(14);
    check_eq("branch_flushes", {16'd0, FlushCnt}, 32'd1);
    check_eq("branch_stalls", {16'd0, StallCnt}, 32'd0);

    // Jump in Mem while lw/add load-use pair sits in Ex/ID
    prog = '{mk(0,0,0,0,0,0,0,1,3), mk(1,2,2,1,0,1,1,0,0), mk(2,4,3,1,1,1,0,0,0),
             mk(1,1,13,1,1,1,0,0,0)};
    do_reset();
    run(12);
    check_eq("redir_ld_flushes", {16'd0, FlushCnt}, 32'd1);
    check_eq("redir_ld_stalls", {16'd0, StallCnt}, 32'd0);

    // Five load-use pairs saturate the 2-bit counter copy
    prog.delete();
    for (int k = 0; k < 5; k++) begin
      prog.push_back(mk(1,2,2,1,0,1,1,0,0));
      prog.push_back(mk(2,2,3,1,1,1,0,0,0));
    end
    do_reset();
    run(24);
    check_eq("sat_stalls_wide", {16'd0, StallCnt}, 32'd5);
    check_eq("sat_stalls_narrow", {30'd0, n_sc}, 32'd3);

    // Asynchronous reset in the bubble cycle after a stall
    prog = '{mk(1,2,2,1,0,1,1,0,0), mk(2,4,3,1,1,1,0,0,0)};
    do_reset();
    run(3);
    check_eq("pre_reset_stall_cnt", {16'd0, StallCnt}, 32'd1);
    #2 Reset = 1;
    #1;
    check_eq("async_rst_valid", {28'd0, D_Valid, E_Valid, M_Valid, W_Valid}, 32'd0);
    check_eq("async_rst_stall_cnt", {16'd0, StallCnt}, 32'd0);
    check_eq("async_rst_ctl", {27'd0, PC_WE, IFID_WE, IFID_Flush, IDEX_Flush, EXMEM_Flush}, 32'h07);
    @(posedge Clk);
    #1;
    do_reset();
    run(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
